// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : single-outstanding load/store unit bridging a pipeline
//                   request port to a word bus, with alignment and timeout.
// Revision        : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_store_option,
    input  logic [2:0]  req_load_option,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] Dout,
    output logic [31:0] Addr,
    output logic [2:0]  load_option,
    output logic        rsp_valid,
    output logic        stall,
    output logic        misalign,
    output logic        timeout_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] acc_addr_q, acc_addr_d;
    logic [2:0]  acc_lopt_q, acc_lopt_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [2:0]  lopt_out_q, lopt_out_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        w_accept;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_accept = req_valid && (state_q == S_IDLE) && (req_read || req_write);

    // Write takes precedence when both read and write are flagged.
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = req_wdata;
        if (req_write) begin
            case (req_store_option)
                2'b01: begin
                    w_misaligned = req_addr[0];
                    w_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata      = {2{req_wdata[15:0]}};
                end
                2'b10: begin
                    w_be    = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                default: w_misaligned = (req_addr[1:0] != 2'b00);
            endcase
        end else begin
            case (req_load_option)
                3'b000:        w_misaligned = (req_addr[1:0] != 2'b00);
                3'b001, 3'b010: w_misaligned = req_addr[0];
                default:       w_misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        acc_addr_d  = acc_addr_q;
        acc_lopt_d  = acc_lopt_q;
        dout_d      = dout_q;
        addr_out_d  = addr_out_q;
        lopt_out_d  = lopt_out_q;
        rsp_valid_d = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        rsp_valid_d = 1'b1;
                        misalign_d  = 1'b1;
                        dout_d      = 32'h0;
                        addr_out_d  = req_addr;
                        lopt_out_d  = req_load_option;
                    end else begin
                        state_d     = S_BUSY;
                        cnt_d       = 8'h0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_write;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = w_be;
                        bus_wdata_d = w_wdata;
                        acc_addr_d  = req_addr;
                        acc_lopt_d  = req_load_option;
                    end
                end
            end
            S_BUSY: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (bus_ack) begin
                    state_d     = S_IDLE;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    dout_d      = bus_we_q ? 32'h0 : bus_rdata;
                    addr_out_d  = acc_addr_q;
                    lopt_out_d  = acc_lopt_q;
                end else if (cnt_q == c_cnt_last) begin
                    state_d     = S_IDLE;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    dout_d      = 32'h0;
                    addr_out_d  = acc_addr_q;
                    lopt_out_d  = acc_lopt_q;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            acc_addr_q  <= 32'h0;
            acc_lopt_q  <= 3'h0;
            dout_q      <= 32'h0;
            addr_out_q  <= 32'h0;
            lopt_out_q  <= 3'h0;
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            acc_addr_q  <= acc_addr_d;
            acc_lopt_q  <= acc_lopt_d;
            dout_q      <= dout_d;
            addr_out_q  <= addr_out_d;
            lopt_out_q  <= lopt_out_d;
            rsp_valid_q <= rsp_valid_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign stall       = (state_q == S_BUSY);
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign Dout        = dout_q;
    assign Addr        = addr_out_q;
    assign load_option = lopt_out_q;
    assign rsp_valid   = rsp_valid_q;
    assign misalign    = misalign_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : scoreboard bench for mem_access_unit (TIMEOUT_CYCLES=4)
// Revision           : 1.0
// ============================================================================
module tb_mem_access_unit;

    typedef struct packed {
        logic [31:0] dout;
        logic [31:0] addr;
        logic [2:0]  lopt;
        logic        mis;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn, req_valid, req_ready, req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_store_option;
    logic [2:0]  req_load_option;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic [31:0] Dout, Addr;
    logic [2:0]  load_option;
    logic        rsp_valid, stall, misalign, timeout_err;

    rsp_t sb[$];
    rsp_t exp_r;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_store_option(req_store_option), .req_load_option(req_load_option),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .Dout(Dout), .Addr(Addr), .load_option(load_option), .rsp_valid(rsp_valid),
        .stall(stall), .misalign(misalign), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request through its acceptance edge, then scramble the inputs.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] so, input logic [2:0] lo);
        req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = a;
        req_wdata = wd; req_store_option = so; req_load_option = lo;
        tick();
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5A5A_5A5A;
        req_store_option = 2'b11; req_load_option = 3'b111;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_store_option = 2'b00; req_load_option = 3'b000;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();
        n_cmp++; if (req_ready !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL reset_ready got rdy=%b stall=%b exp 1/0", req_ready, stall); end
        n_cmp++; if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin n_err++; $display("FAIL reset_bus got req=%b be=%h addr=%h exp 0", bus_req, bus_be, bus_addr); end
        n_cmp++; if ({Dout, Addr, load_option, rsp_valid, misalign, timeout_err} !== 70'h0) begin n_err++; $display("FAIL reset_rsp got dout=%h addr=%h rsp=%b exp 0", Dout, Addr, rsp_valid); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        sb.push_back('{dout:32'hCAFEBABE, addr:32'h1000, lopt:3'b000, mis:1'b0, tmo:1'b0});
        issue(1'b1, 1'b0, 32'h1000, 32'h0, 2'b00, 3'b000);
        n_cmp++; if ({bus_req, bus_we, bus_be, stall, req_ready} !== 8'b1_0_1111_1_0) begin n_err++; $display("FAIL lw_bus got req=%b we=%b be=%b stall=%b rdy=%b exp 1 0 1111 1 0", bus_req, bus_we, bus_be, stall, req_ready); end
        n_cmp++; if (bus_addr !== 32'h1000) begin n_err++; $display("FAIL lw_addr got %h exp 00001000", bus_addr); end
        tick(); tick(); tick();
        n_cmp++; if (bus_req !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_hold got req=%b rsp=%b exp 1/0", bus_req, rsp_valid); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFEBABE;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_cmp++; if (rsp_valid !== 1'b1 || bus_req !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL lw_done got rsp=%b req=%b rdy=%b exp 1 0 1", rsp_valid, bus_req, req_ready); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL lw_rsp got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || Dout !== 32'hCAFEBABE || Addr !== 32'h1000) begin n_err++; $display("FAIL lw_hold_out got rsp=%b dout=%h addr=%h exp 0 cafebabe 1000", rsp_valid, Dout, Addr); end
    endtask

    task automatic test_sb();
        int c0;
        sb.push_back('{dout:32'h0, addr:32'h2003, lopt:3'b101, mis:1'b0, tmo:1'b0});
        c0 = cyc;
        issue(1'b0, 1'b1, 32'h2003, 32'h0000_00A5, 2'b10, 3'b101);
        n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 4'b1000, 32'h2000, 32'hA5A5A5A5}) begin n_err++; $display("FAIL sb_bus got we=%b be=%b addr=%h wd=%h exp 1 1000 2000 a5a5a5a5", bus_we, bus_be, bus_addr, bus_wdata); end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_ack = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || cyc - c0 !== 2) begin n_err++; $display("FAIL sb_latency got rsp=%b lat=%0d exp 1 2", rsp_valid, cyc - c0); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL sb_rsp got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
    endtask

    task automatic test_misalign();
        sb.push_back('{dout:32'h0, addr:32'h3001, lopt:3'b001, mis:1'b1, tmo:1'b0});
        issue(1'b1, 1'b0, 32'h3001, 32'h0, 2'b00, 3'b001);
        n_cmp++; if ({rsp_valid, misalign, bus_req, req_ready} !== 4'b1101) begin n_err++; $display("FAIL lh_mis got rsp=%b mis=%b req=%b rdy=%b exp 1 1 0 1", rsp_valid, misalign, bus_req, req_ready); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL lh_rsp got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
        n_cmp++; if (misalign !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL lh_pulse got mis=%b rsp=%b exp 0 0", misalign, rsp_valid); end
        // A misaligned SW is flagged too.
        issue(1'b0, 1'b1, 32'h3002, 32'h0, 2'b00, 3'b000);
        n_cmp++; if (misalign !== 1'b1 || bus_req !== 1'b0) begin n_err++; $display("FAIL sw_mis got mis=%b req=%b exp 1 0", misalign, bus_req); end
        tick();
    endtask

    task automatic test_ignored();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        bus_ack = 1'b1;
        tick(); tick();
        bus_ack = 1'b0;
        n_cmp++; if ({bus_req, rsp_valid, stall} !== 3'b000) begin n_err++; $display("FAIL ignore got req=%b rsp=%b stall=%b exp 0 0 0", bus_req, rsp_valid, stall); end
    endtask

    task automatic test_timeout();
        int n;
        sb.push_back('{dout:32'h0, addr:32'h500, lopt:3'b000, mis:1'b0, tmo:1'b1});
        issue(1'b1, 1'b0, 32'h500, 32'h0, 2'b00, 3'b000);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus_req) break;
            n++;
            tick();
        end
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL tmo_cycles got %0d exp 4", n); end
        n_cmp++; if ({timeout_err, rsp_valid, req_ready} !== 3'b111) begin n_err++; $display("FAIL tmo_flags got tmo=%b rsp=%b rdy=%b exp 1 1 1", timeout_err, rsp_valid, req_ready); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL tmo_rsp got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
        // Ack on the final allowed cycle beats the timeout.
        sb.push_back('{dout:32'h12345678, addr:32'h600, lopt:3'b000, mis:1'b0, tmo:1'b0});
        issue(1'b1, 1'b0, 32'h600, 32'h0, 2'b00, 3'b000);
        tick(); tick(); tick();
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL tmo_race_rsp got %b exp 1", rsp_valid); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL tmo_race got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(1'b0, 1'b1, 32'h80, 32'h0BAD_0BAD, 2'b00, 3'b000);
        tick();
        rstn = 1'b0;
        tick();
        n_cmp++; if (bus_req !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_abort got req=%b rsp=%b exp 0 0", bus_req, rsp_valid); end
        rstn = 1'b1; bus_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        bus_ack = 1'b0;
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_ghost got %0d responses exp 0", seen); end
        sb.push_back('{dout:32'h0, addr:32'h40, lopt:3'b000, mis:1'b0, tmo:1'b0});
        issue(1'b0, 1'b1, 32'h40, 32'h11223344, 2'b00, 3'b000);
        n_cmp++; if ({bus_req, bus_be, bus_wdata, bus_addr} !== {1'b1, 4'hF, 32'h11223344, 32'h40}) begin n_err++; $display("FAIL sw_bus got req=%b be=%b wd=%h addr=%h exp 1 1111 11223344 40", bus_req, bus_be, bus_wdata, bus_addr); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        exp_r = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || {Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL sw_rsp got rsp=%b %h exp 1 %h", rsp_valid, {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        sb.push_back('{dout:32'h0, addr:32'h10, lopt:3'b000, mis:1'b0, tmo:1'b0});
        sb.push_back('{dout:32'h0, addr:32'h12, lopt:3'b000, mis:1'b0, tmo:1'b0});
        issue(1'b0, 1'b1, 32'h10, 32'h0000_BEEF, 2'b01, 3'b000);
        n_cmp++; if (bus_be !== 4'b0011 || bus_wdata !== 32'hBEEFBEEF) begin n_err++; $display("FAIL b2b_sh0 got be=%b wd=%h exp 0011 beefbeef", bus_be, bus_wdata); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        c1 = cyc;
        n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rsp0 got rsp=%b rdy=%b exp 1 1", rsp_valid, req_ready); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL b2b_d0 got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        issue(1'b0, 1'b1, 32'h12, 32'h0000_1234, 2'b01, 3'b000);
        n_cmp++; if (bus_be !== 4'b1100 || bus_wdata !== 32'h12341234 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_sh1 got be=%b wd=%h rsp=%b exp 1100 12341234 0", bus_be, bus_wdata, rsp_valid); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        c2 = cyc;
        n_cmp++; if (rsp_valid !== 1'b1 || c2 - c1 !== 2) begin n_err++; $display("FAIL b2b_gap got rsp=%b gap=%0d exp 1 2", rsp_valid, c2 - c1); end
        exp_r = sb.pop_front();
        n_cmp++; if ({Dout, Addr, load_option, misalign, timeout_err} !== exp_r) begin n_err++; $display("FAIL b2b_d1 got %h exp %h", {Dout, Addr, load_option, misalign, timeout_err}, exp_r); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_misalign();
        test_ignored();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain got %0d left exp 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles bus_req held without bus_ack before abort (range 1..255).
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port: rstn  input  1  synchronous active-low reset.
REQ-005 SHALL have ports: req_valid in 1 request valid; req_ready out 1 unit can accept; req_read in 1 load; req_write in 1 store.
REQ-006 SHALL have ports: req_addr in 32 byte address; req_wdata in 32 store data (LSB-aligned); req_store_option in 2 (00 SW, 01 SH, 10 SB, 11 treated as SW); req_load_option in 3 (opaque, passed through).
REQ-007 SHALL have ports: bus_req out 1; bus_we out 1; bus_addr out 32 word-aligned; bus_wdata out 32; bus_be out 4; bus_ack in 1; bus_rdata in 32.
REQ-008 SHALL have ports: Dout out 32 raw word; Addr out 32 original byte address; load_option out 3; rsp_valid out 1 one-cycle response strobe.
REQ-009 SHALL have ports: stall out 1 pipeline hold; misalign out 1 pulse; timeout_err out 1 pulse.

Function
REQ-010 SHALL implement FSM IDLE, BUSY; req_ready = (state==IDLE); stall = (state==BUSY).
REQ-011 SHALL accept a request on a cycle with req_valid && req_ready && (req_read || req_write); req_valid with neither flag set SHALL be ignored (no bus access, no rsp_valid).
REQ-012 SHALL treat req_read && req_write both set as a write.
REQ-013 SHALL register req_addr, req_load_option and the access type at acceptance; later input changes SHALL NOT affect the access.
REQ-014 SHALL flag misaligned accesses at acceptance: word with addr[1:0]!=0, halfword (load or store) with addr[0]!=0; loads halfword = load_option 001/010; loads word = 000.
REQ-015 On misaligned accept (cycle N): no bus_req; in N+1 misalign=1, rsp_valid=1, Dout=0, Addr=req_addr; state stays IDLE.
REQ-016 On aligned accept (cycle N): state BUSY in N+1, bus_req=1 from N+1 with bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata held stable until ack.
REQ-017 Byte enables/data: reads be=1111; SW be=1111 wdata=req_wdata; SH be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}; SB be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
REQ-018 bus_ack sampled high in cycle M (M>=N+1) SHALL complete access: in M+1 bus_req=0, state IDLE, rsp_valid=1, Dout=bus_rdata captured in M (reads) or 0 (writes), Addr and load_option = registered values.
REQ-019 Minimum accept-to-rsp_valid latency SHALL be 2 cycles; next request acceptable in M+1 (back-to-back).
REQ-020 A timeout counter SHALL count BUSY cycles; on reaching TIMEOUT_CYCLES without ack: bus_req dropped next cycle, timeout_err=1, rsp_valid=1, Dout=0, state IDLE.
REQ-021 bus_ack in the same cycle the timeout is reached SHALL win: normal completion, no timeout_err.
REQ-022 bus_ack while IDLE SHALL be ignored.
REQ-023 Dout, Addr, load_option SHALL hold their last values between rsp_valid pulses; misalign, timeout_err, rsp_valid are single-cycle pulses.

Reset
REQ-024 With rstn low at a rising edge: state IDLE, counter 0, bus_req, bus_we, bus_be, bus_wdata, bus_addr, Dout, Addr, load_option, rsp_valid, misalign, timeout_err all 0.
REQ-025 Reset mid-access SHALL abort: bus_req low after the reset edge, no rsp_valid; a later bus_ack SHALL be ignored.

Verification
REQ-026 LW addr 0x1000, ack 3 cycles after bus_req, rdata 0xCAFEBABE -> bus_be=1111, rsp_valid 1 cycle after ack, Dout=0xCAFEBABE, Addr=0x1000.
REQ-027 SB addr 0x2003 wdata 0x000000A5, immediate ack -> bus_addr=0x2000, be=1000, wdata=0xA5A5A5A5, rsp_valid at accept+2.
REQ-028 LH addr 0x3001 -> no bus_req, misalign=1 and rsp_valid=1 next cycle, Dout=0.
REQ-029 TIMEOUT_CYCLES=4, no ack -> bus_req 4 cycles, then timeout_err=1, rsp_valid=1, Dout=0, req_ready=1.
REQ-030 rstn low 2 cycles into BUSY, then ack -> bus_req=0 after reset edge, no rsp_valid; next SW addr 0x40 completes normally.
REQ-031 Two back-to-back SH (0x10 then 0x12, immediate acks) -> be 0011 then 1100, two rsp_valid pulses 2 cycles apart.
